dpram_fifo_ctrl: RTL and testbench
==================================

Name: dpram_fifo_ctrl

Overview:
- Pointer/flag controller placed directly upstream of the negedge-clocked dual-port RAM (DW-bit data, AW-bit addresses, we/re enables, registered read output that floats to Z when re=0).
- Turns a valid/ready push stream and a valid/ready pop stream into RAM we/re/WAdr/RAdr, so the RAM behaves as a synchronous FIFO.
- Captures RAM read data on the posedge and presents it as a registered pop_data/pop_data_valid pair.
- Also provides occupancy count, full/empty/almost-full status and sticky overflow/underflow flags.

Parameters:
- DW, 8, data width; equals RAM data width.
- AW, 5, address width; equals RAM address width.
- DEPTH, 5, number of RAM entries used. Must satisfy 2 <= DEPTH <= 2^AW and must not exceed the RAM's physical entry count. Non-power-of-two is legal.
- AFULL_TH, 4, almost_full asserts when count >= AFULL_TH.

Ports:
- clk  in  1  single clock. Controller logic on posedge; the RAM samples the ram_* outputs on negedge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous pointer/flag clear. Memory contents are untouched.
- push_valid  in  1  producer has a word.
- push_data  in  DW  producer word.
- push_ready  out  1  = !full.
- pop_valid  in  1  consumer requests a word.
- pop_ready  out  1  = !empty.
- pop_data  out  DW  registered read word.
- pop_data_valid  out  1  one-cycle strobe; pop_data is new.
- ram_we  out  1  to RAM we.
- ram_re  out  1  to RAM re.
- ram_waddr  out  AW  to RAM WAdr.
- ram_raddr  out  AW  to RAM RAdr.
- ram_wdata  out  DW  to RAM write.
- ram_rdata  in  DW  from RAM read.
- count  out  AW+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- ovf  out  1  sticky: push_valid seen while full.
- udf  out  1  sticky: pop_valid seen while empty.

Behaviour:
- Reset, when rst_n=0 at posedge: wr_ptr=0, rd_ptr=0, count=0, pop_data=0, pop_data_valid=0, ovf=0, udf=0. Resulting outputs: empty=1, full=0, almost_full=0, push_ready=1, pop_ready=0.
- Gating: while rst_n=0 or flush=1, ram_we and ram_re are forced 0 combinationally. The RAM therefore neither writes nor reads at the negedge inside a reset or flush cycle. This applies equally to reset asserted mid-stream.
- push_fire = push_valid & push_ready & rst_n & !flush.
- pop_fire = pop_valid & pop_ready & rst_n & !flush.
- ram_we = push_fire; ram_waddr = wr_ptr; ram_wdata = push_data (all combinational).
- ram_re = pop_fire; ram_raddr = rd_ptr (combinational).
- Timing contract: push_valid, push_data, pop_valid, flush and rst_n must settle within the first half-cycle after posedge, because the RAM samples at the intervening negedge.
- Write path: the RAM writes at the negedge inside cycle k. On posedge closing cycle k, wr_ptr advances. The word is readable by a pop in cycle k+1.
- Read path: the RAM drives ram_rdata from the negedge inside cycle k. On posedge closing cycle k, pop_data <= ram_rdata, pop_data_valid <= 1, rd_ptr advances.
  - Latency: data is visible in the cycle after the pop handshake.
  - Without pop_fire: pop_data holds its value, pop_data_valid <= 0. The Z bus from the RAM is never captured.
- Pointer wrap: ptr == DEPTH-1 -> 0, otherwise ptr+1.
- count update:
  - +1 on push_fire only.
  - -1 on pop_fire only.
  - unchanged on both or neither.
- Simultaneous push and pop (0 < count < DEPTH):
  - Both fire; count unchanged.
  - Addresses are necessarily distinct, so the RAM's write-first same-address path is never exercised.
- Full: push_ready=0. A push_valid in this cycle is dropped and sets ovf. A pop in the same cycle is still served, and count becomes DEPTH-1.
- Empty: pop_ready=0. A pop_valid in this cycle sets udf, ram_re=0 and pop_data_valid=0 next cycle. A push in the same cycle is still accepted. There is no bypass: the word is poppable next cycle.
- Flush (rst_n=1, flush=1): pointers, count, ovf and udf clear to 0; pop_data_valid <= 0; pop_data holds. Flush has priority over push/pop in the same cycle. Reset has priority over flush.
- ovf/udf: sticky until reset or flush. They set in the cycle after the offending request.

Test Plan:
- Reset then idle:
  - rst_n=0 for 2 cycles, then 1 -> empty=1, count=0, pop_ready=0, ram_we=ram_re=0, pop_data=0x00.
  - Hold rst_n=0 with push_valid=1 -> no RAM write.
- Fill/drain with wrap:
  - Push 0x11..0x15 -> full=1 after the 5th push, count=5, almost_full from count=4.
  - Pop 5 -> pop_data 0x11..0x15, each one cycle after its handshake.
  - Push 0xA0,0xA1 -> ram_waddr 0 then 1 (wrap from 4).
- Overflow/underflow:
  - 6th push while full -> word dropped, ovf=1, count stays 5.
  - Pop on empty -> udf=1, pop_data_valid stays 0, pop_data unchanged.
- Concurrent traffic:
  - From count=2, push and pop every cycle for 12 cycles -> count stays 2, output order equals input order, pointers wrap mod 5.
  - Full + push + pop -> only the pop fires.
- Flush mid-stream:
  - count=3, flush=1 together with push_valid=pop_valid=1 -> ram_we=ram_re=0, next cycle count=0, empty=1, ovf=udf=0, pop_data_valid=0.
- Reset mid-operation:
  - rst_n=0 during a concurrent push/pop cycle -> no RAM write or read at that negedge, all state cleared next posedge.
  - Subsequent push of 0x3C then pop -> pop_data=0x3C.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// Pointer/flag controller that turns valid/ready push and pop streams into negedge dual-port RAM controls.
// Latency: a pushed word is poppable the next cycle; popped data appears on pop_data one cycle after the pop handshake.
// Backpressure: push_ready = !full, pop_ready = !empty; refused requests set sticky ovf/udf flags.
//
// The attached RAM samples we/re/addresses on the negedge, so every ram_* output here is
// combinational from the posedge-registered pointers and the (early-settling) request inputs.
// DEPTH must lie in 2..2^AW and must not exceed the physical RAM size; non-power-of-two is fine.
module dpram_fifo_ctrl #(
  parameter int DW       = 8,
  parameter int AW       = 5,
  parameter int DEPTH    = 5,
  parameter int AFULL_TH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop_valid,
  output logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic          pop_data_valid,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_CNT = (AW+1)'(AFULL_TH);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] pop_data_q, pop_data_d;
  logic          pop_data_valid_q, pop_data_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          run;
  logic          push_fire;
  logic          pop_fire;

  // Pointers wrap at DEPTH rather than at 2^AW so odd depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  // Status flags and handshakes; reset and flush both gate the RAM strobes off.
  always_comb begin
    full        = (count_q == DEPTH_CNT);
    empty       = (count_q == '0);
    almost_full = (count_q >= AFULL_CNT);
    push_ready  = ~full;
    pop_ready   = ~empty;
    run         = rst_n & ~flush;
    push_fire   = push_valid & push_ready & run;
    pop_fire    = pop_valid & pop_ready & run;
  end

  // RAM-facing controls, sampled by the RAM on the following negedge.
  always_comb begin
    ram_we    = push_fire;
    ram_waddr = wr_ptr_q;
    ram_wdata = push_data;
    ram_re    = pop_fire;
    ram_raddr = rd_ptr_q;
  end

  // Next-state: flush clears pointers and flags but leaves the last popped word visible.
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    pop_data_d       = pop_data_q;
    pop_data_valid_d = 1'b0;
    ovf_d            = ovf_q;
    udf_d            = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_fire) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_fire) begin
        // RAM drove ram_rdata from the mid-cycle negedge; only captured when a read was issued.
        rd_ptr_d         = ptr_inc(rd_ptr_q);
        pop_data_d       = ram_rdata;
        pop_data_valid_d = 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (push_valid && full) begin
        ovf_d = 1'b1;
      end
      if (pop_valid && empty) begin
        udf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      pop_data_q       <= '0;
      pop_data_valid_q <= 1'b0;
      ovf_q            <= 1'b0;
      udf_q            <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      pop_data_q       <= pop_data_d;
      pop_data_valid_q <= pop_data_valid_d;
      ovf_q            <= ovf_d;
      udf_q            <= udf_d;
    end
  end

  // Registered outputs.
  always_comb begin
    count          = count_q;
    pop_data       = pop_data_q;
    pop_data_valid = pop_data_valid_q;
    ovf            = ovf_q;
    udf            = udf_q;
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: directed scenarios followed by random traffic, checked against a queue model.
// Latency: inputs change 1 time unit after posedge, outputs are sampled 2 units after posedge.
// Backpressure: the model decides acceptance from its own occupancy, independent of DUT flags.
module tb_dpram_fifo_ctrl;

  localparam int DW       = 8;
  localparam int AW       = 5;
  localparam int DEPTH    = 5;
  localparam int AFULL_TH = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic          pop_data_valid;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          ovf;
  logic          udf;

  dpram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .ram_we(ram_we), .ram_re(ram_re), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Negedge dual-port RAM, write-first on same address, read bus floats when not reading.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  always @(negedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) rd_q <= (ram_we && ram_waddr == ram_raddr) ? ram_wdata : mem[ram_raddr];
    else        rd_q <= 'z;
  end
  assign ram_rdata = rd_q;

  // Reference model: FIFO contents as a queue plus positions counted modulo DEPTH.
  logic [DW-1:0] mq[$];
  int            m_wpos, m_rpos;
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_pd;
  logic          m_pdv;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_wpos = 0; m_rpos = 0;
    m_ovf = 1'b0; m_udf = 1'b0;
    m_pd = '0; m_pdv = 1'b0;
  endtask

  // One clock cycle: drive, check combinational view, advance model, check registered pop data.
  task automatic cycle(input logic r, input logic f, input logic pv, input logic [DW-1:0] pd, input logic qv);
    int  sz;
    logic e_full, e_empty, e_we, e_re;
    rst_n = r; flush = f; push_valid = pv; push_data = pd; pop_valid = qv;
    #1;
    sz      = mq.size();
    e_full  = (sz == DEPTH);
    e_empty = (sz == 0);
    e_we    = r && !f && pv && !e_full;
    e_re    = r && !f && qv && !e_empty;
    chk("count",       32'(count),       32'(sz));
    chk("full",        32'(full),        32'(e_full));
    chk("empty",       32'(empty),       32'(e_empty));
    chk("almost_full", 32'(almost_full), 32'(sz >= AFULL_TH));
    chk("push_ready",  32'(push_ready),  32'(!e_full));
    chk("pop_ready",   32'(pop_ready),   32'(!e_empty));
    chk("ovf",         32'(ovf),         32'(m_ovf));
    chk("udf",         32'(udf),         32'(m_udf));
    chk("ram_we",      32'(ram_we),      32'(e_we));
    chk("ram_re",      32'(ram_re),      32'(e_re));
    if (e_we) begin
      chk("ram_waddr", 32'(ram_waddr), 32'(m_wpos));
      chk("ram_wdata", 32'(ram_wdata), 32'(pd));
    end
    if (e_re) chk("ram_raddr", 32'(ram_raddr), 32'(m_rpos));
    // Model update at the closing posedge.
    if (!r) begin
      model_reset();
    end else if (f) begin
      mq.delete();
      m_wpos = 0; m_rpos = 0;
      m_ovf = 1'b0; m_udf = 1'b0;
      m_pdv = 1'b0;
    end else begin
      if (pv && e_full)  m_ovf = 1'b1;
      if (qv && e_empty) m_udf = 1'b1;
      m_pdv = e_re;
      if (e_re) begin
        m_pd   = mq.pop_front();
        m_rpos = (m_rpos + 1) % DEPTH;
      end
      if (e_we) begin
        mq.push_back(pd);
        m_wpos = (m_wpos + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
    chk("pop_data_valid", 32'(pop_data_valid), 32'(m_pdv));
    chk("pop_data",       32'(pop_data),       32'(m_pd));
  endtask

  task automatic push(input logic [DW-1:0] d); cycle(1'b1, 1'b0, 1'b1, d, 1'b0); endtask
  task automatic pop();                        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1); endtask
  task automatic idle();                       cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a push request: no write may happen.
    cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
    idle();

    // Fill to full, then one dropped push.
    for (int i = 0; i < DEPTH; i++) push(8'(8'h11 + i));
    push(8'h16);
    // Drain, then pop while empty.
    for (int i = 0; i < DEPTH; i++) pop();
    pop();
    idle();
    // Wrapped writes.
    push(8'hA0);
    push(8'hA1);

    // Concurrent push and pop from count = 2.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1);
    pop();

    // Full with push and pop together: only the pop fires.
    while (mq.size() < DEPTH) push(8'($urandom));
    cycle(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
    pop();

    // Flush at count = 3 with both requests raised.
    chk("pre_flush_count", 32'(count), 32'd3);
    cycle(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
    idle();

    // Reset in the middle of concurrent traffic.
    push(8'h21);
    push(8'h22);
    cycle(1'b0, 1'b0, 1'b1, 8'h23, 1'b1);
    push(8'h3C);
    pop();
    chk("pop_3c", 32'(pop_data), 32'h3C);
    idle();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 5));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
